dcache_port_arbiter: RTL and testbench

- Shares a single data-cache request port between NrPorts requesters: load unit, store unit and PTW.
- Fair round-robin arbitration; once a request is presented downstream, the grant is held until handshake completion.
- Records the issuing port of every granted request in an in-order FIFO so each response is routed back to its originator.
- Sits between the LSU/MMU and the dcache in the CVA6 core.

---
 rtl/dcache_arb_pkg.sv | 24 ++
 rtl/dcache_port_arbiter_fifo.sv | 64 ++++++
 rtl/dcache_port_arbiter.sv | 112 +++++++++++
 tb/tb_dcache_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_arb_pkg.sv
// Shared types for the dcache port arbiter.
// The default-config request/index types are sized from the Def* constants.
package dcache_arb_pkg;

   localparam int unsigned DefNrPorts        = 3;
   localparam int unsigned DefAddrWidth      = 64;
   localparam int unsigned DefDataWidth      = 64;
   localparam int unsigned DefMaxOutstanding = 4;

   typedef logic [$clog2(DefNrPorts)-1:0] port_idx_t;

   typedef struct packed {
      logic [DefAddrWidth-1:0]   addr;
      logic                      we;
      logic [DefDataWidth-1:0]   wdata;
      logic [DefDataWidth/8-1:0] be;
   } dcache_req_t;

   typedef enum logic {
      Idle,
      Hold
   } arb_state_e;

endpackage

// File: rtl/dcache_port_arbiter_fifo.sv
// In-order FIFO holding the issuing port index of each granted request.
// A pop in the same cycle does not make room for a push while full.
module dcache_port_arbiter_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = PtrW + 1;

   logic [Depth-1:0][Width-1:0] mem_q, mem_d;
   logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]             cnt_q, cnt_d;
   logic                        do_push, do_pop;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push_i & ~full_o;
      do_pop   = pop_i & ~empty_o;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing one dcache request port among NrPorts requesters,
// routing each in-order response back to the port that issued the request.
module dcache_port_arbiter
   import dcache_arb_pkg::*;
#(
   parameter int unsigned NrPorts        = DefNrPorts,
   parameter int unsigned AddrWidth      = DefAddrWidth,
   parameter int unsigned DataWidth      = DefDataWidth,
   parameter int unsigned MaxOutstanding = DefMaxOutstanding
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NrPorts-1:0]                    req_i,
   input  logic [NrPorts-1:0][AddrWidth-1:0]     addr_i,
   input  logic [NrPorts-1:0]                    we_i,
   input  logic [NrPorts-1:0][DataWidth-1:0]     wdata_i,
   input  logic [NrPorts-1:0][DataWidth/8-1:0]   be_i,
   output logic [NrPorts-1:0]                    gnt_o,
   output logic [NrPorts-1:0]                    rvalid_o,
   output logic [DataWidth-1:0]                  rdata_o,
   output logic                                  req_o,
   output logic [AddrWidth-1:0]                  addr_o,
   output logic                                  we_o,
   output logic [DataWidth-1:0]                  wdata_o,
   output logic [DataWidth/8-1:0]                be_o,
   input  logic                                  gnt_i,
   input  logic                                  rvalid_i,
   input  logic [DataWidth-1:0]                  rdata_i,
   output logic                                  resp_err_o
);

   localparam int unsigned IdxW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
   typedef logic [IdxW-1:0] idx_t;

   arb_state_e state_q, state_d;
   idx_t       rr_ptr_q, rr_ptr_d, hold_idx_q, hold_idx_d;
   idx_t       rr_sel, sel, fifo_head;
   logic       resp_err_q, resp_err_d;
   logic       fifo_full, fifo_empty, push, pop;
   int unsigned cand;

   // First requesting port at or after rr_ptr, wrapping modulo NrPorts.
   always_comb begin
      rr_sel = rr_ptr_q;
      cand   = 0;
      for (int unsigned i = 0; i < NrPorts; i++) begin
         cand = (32'(rr_ptr_q) + i) % NrPorts;
         if (req_i[cand] && (rr_sel == rr_ptr_q) && !req_i[rr_ptr_q] && i != 0) begin
            rr_sel = idx_t'(cand);
         end
      end
   end

   always_comb begin
      sel        = (state_q == Hold) ? hold_idx_q : rr_sel;
      req_o      = (state_q == Hold) ? 1'b1 : ((|req_i) && !fifo_full);
      push       = req_o & gnt_i;
      gnt_o      = '0;
      gnt_o[sel] = push;
      addr_o     = addr_i[sel];
      we_o       = we_i[sel];
      wdata_o    = wdata_i[sel];
      be_o       = be_i[sel];

      state_d    = state_q;
      hold_idx_d = hold_idx_q;
      rr_ptr_d   = rr_ptr_q;
      if (push) begin
         rr_ptr_d = (sel == idx_t'(NrPorts - 1)) ? '0 : sel + idx_t'(1);
         state_d  = Idle;
      end else if (req_o && state_q == Idle) begin
         hold_idx_d = sel;
         state_d    = Hold;
      end

      pop                 = rvalid_i & ~fifo_empty;
      rvalid_o            = '0;
      rvalid_o[fifo_head] = pop;
      rdata_o             = rdata_i;
      resp_err_d          = resp_err_q | (rvalid_i & fifo_empty);
      resp_err_o          = resp_err_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= Idle;
         rr_ptr_q   <= '0;
         hold_idx_q <= '0;
         resp_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_idx_q <= hold_idx_d;
         resp_err_q <= resp_err_d;
      end
   end

   dcache_port_arbiter_fifo #(
      .Depth (MaxOutstanding),
      .Width (IdxW)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (sel),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: stimulus queues expected grants and
// responses, a negedge monitor pops and compares whenever the DUT presents one.
module tb_dcache_port_arbiter;
   import dcache_arb_pkg::*;

   localparam int unsigned NP = 3;
   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [NP-1:0]              req;
   logic [NP-1:0][AW-1:0]      addr;
   logic [NP-1:0]              we;
   logic [NP-1:0][DW-1:0]      wdata;
   logic [NP-1:0][DW/8-1:0]    be;
   logic [NP-1:0]              gnt_o, rvalid_o;
   logic [DW-1:0]              rdata_o, wdata_o, rdata_in;
   logic                       req_o, we_o, gnt_in, rvalid_in, resp_err_o;
   logic [AW-1:0]              addr_o;
   logic [DW/8-1:0]            be_o;

   always #5 clk = ~clk;

   dcache_port_arbiter dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_i      (req),
      .addr_i     (addr),
      .we_i       (we),
      .wdata_i    (wdata),
      .be_i       (be),
      .gnt_o      (gnt_o),
      .rvalid_o   (rvalid_o),
      .rdata_o    (rdata_o),
      .req_o      (req_o),
      .addr_o     (addr_o),
      .we_o       (we_o),
      .wdata_o    (wdata_o),
      .be_o       (be_o),
      .gnt_i      (gnt_in),
      .rvalid_i   (rvalid_in),
      .rdata_i    (rdata_in),
      .resp_err_o (resp_err_o)
   );

   typedef struct packed {
      logic [NP-1:0] oh;
      logic [AW-1:0] a;
      logic          w;
      logic [DW-1:0] d;
   } gnt_exp_t;

   typedef struct packed {
      logic [NP-1:0] oh;
      logic [DW-1:0] d;
   } rsp_exp_t;

   dcache_req_t cfg [NP];
   gnt_exp_t    gq [$];
   rsp_exp_t    rq [$];
   gnt_exp_t    mon_g;
   rsp_exp_t    mon_r;
   int          checks   = 0;
   int          failures = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_gnt(input int k);
      gq.push_back('{oh: NP'(1 << k), a: cfg[k].addr, w: cfg[k].we, d: cfg[k].wdata});
   endtask

   task automatic exp_rsp(input int k, input logic [DW-1:0] d);
      rq.push_back('{oh: NP'(1 << k), d: d});
   endtask

   task automatic drive(input logic [NP-1:0] r, input logic g, input logic rv,
                        input logic [DW-1:0] d);
      req       = r;
      gnt_in    = g;
      rvalid_in = rv;
      rdata_in  = d;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (gnt_o != '0) begin
            if (gq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_gnt: got gnt_o=%b expected none", gnt_o);
            end else begin
               mon_g = gq.pop_front();
               chk("gnt_port", 128'(gnt_o), 128'(mon_g.oh));
               chk("gnt_addr", 128'(addr_o), 128'(mon_g.a));
               chk("gnt_we", 128'(we_o), 128'(mon_g.w));
               chk("gnt_wdata", 128'(wdata_o), 128'(mon_g.d));
            end
         end
         if (rvalid_o != '0) begin
            if (rq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rvalid: got rvalid_o=%b expected none", rvalid_o);
            end else begin
               mon_r = rq.pop_front();
               chk("rsp_port", 128'(rvalid_o), 128'(mon_r.oh));
               chk("rsp_data", 128'(rdata_o), 128'(mon_r.d));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cfg[0] = '{addr: 64'h20, we: 1'b0, wdata: 64'hA0A0, be: 8'hFF};
      cfg[1] = '{addr: 64'h40, we: 1'b1, wdata: 64'hB1B1, be: 8'h0F};
      cfg[2] = '{addr: 64'h80, we: 1'b0, wdata: 64'hC2C2, be: 8'hF0};
      for (int k = 0; k < NP; k++) begin
         addr[k]  = cfg[k].addr;
         we[k]    = cfg[k].we;
         wdata[k] = cfg[k].wdata;
         be[k]    = cfg[k].be;
      end

      rst = 1'b1;
      drive(3'b000, 1'b0, 1'b0, '0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      settle();
      chk("rst_req_o", 128'(req_o), 128'(0));
      chk("rst_gnt_o", 128'(gnt_o), 128'(0));
      chk("rst_rvalid_o", 128'(rvalid_o), 128'(0));
      chk("rst_resp_err", 128'(resp_err_o), 128'(0));
      next_cycle();

      // Fairness: all ports request, downstream always grants and answers next cycle.
      for (int c = 0; c < 6; c++) begin
         drive(3'b111, 1'b1, (c > 0), 64'h100 + 64'(c));
         exp_gnt(c % 3);
         if (c > 0) exp_rsp((c - 1) % 3, 64'h100 + 64'(c));
         settle();
         next_cycle();
      end
      drive(3'b000, 1'b0, 1'b1, 64'h106);
      exp_rsp(2, 64'h106);
      settle();
      next_cycle();
      drive(3'b000, 1'b0, 1'b0, '0);
      settle();
      chk("fair_no_err", 128'(resp_err_o), 128'(0));
      next_cycle();

      // Hold: port 2 stalled downstream, port 0 arrives but must wait.
      drive(3'b100, 1'b0, 1'b0, '0);
      settle();
      chk("hold_req_o", 128'(req_o), 128'(1));
      chk("hold_addr_c0", 128'(addr_o), 128'(64'h80));
      next_cycle();
      for (int c = 1; c < 3; c++) begin
         drive(3'b101, 1'b0, 1'b0, '0);
         settle();
         chk("hold_addr_kept", 128'(addr_o), 128'(64'h80));
         next_cycle();
      end
      drive(3'b101, 1'b1, 1'b0, '0);
      exp_gnt(2);
      settle();
      next_cycle();
      drive(3'b001, 1'b1, 1'b0, '0);
      exp_gnt(0);
      settle();
      next_cycle();
      drive(3'b000, 1'b0, 1'b1, 64'hD0);
      exp_rsp(2, 64'hD0);
      settle();
      next_cycle();
      drive(3'b000, 1'b0, 1'b1, 64'hD1);
      exp_rsp(0, 64'hD1);
      settle();
      next_cycle();

      // Backpressure: fill the FIFO, then a pop must not free a slot that cycle.
      for (int c = 0; c < 4; c++) begin
         drive(3'b010, 1'b1, 1'b0, '0);
         exp_gnt(1);
         settle();
         next_cycle();
      end
      drive(3'b010, 1'b1, 1'b0, '0);
      settle();
      chk("full_req_o", 128'(req_o), 128'(0));
      next_cycle();
      drive(3'b010, 1'b1, 1'b1, 64'hE0);
      exp_rsp(1, 64'hE0);
      settle();
      chk("pop_cycle_req_o", 128'(req_o), 128'(0));
      next_cycle();
      drive(3'b010, 1'b1, 1'b0, '0);
      exp_gnt(1);
      settle();
      chk("after_pop_req_o", 128'(req_o), 128'(1));
      next_cycle();
      for (int c = 1; c <= 4; c++) begin
         drive(3'b000, 1'b0, 1'b1, 64'hE0 + 64'(c));
         exp_rsp(1, 64'hE0 + 64'(c));
         settle();
         next_cycle();
      end

      // Routing: grants 0,2,1 then three responses.
      drive(3'b001, 1'b1, 1'b0, '0);
      exp_gnt(0);
      settle();
      next_cycle();
      drive(3'b100, 1'b1, 1'b0, '0);
      exp_gnt(2);
      settle();
      next_cycle();
      drive(3'b010, 1'b1, 1'b0, '0);
      exp_gnt(1);
      settle();
      next_cycle();
      drive(3'b000, 1'b0, 1'b1, 64'hA);
      exp_rsp(0, 64'hA);
      settle();
      next_cycle();
      drive(3'b000, 1'b0, 1'b1, 64'hB);
      exp_rsp(2, 64'hB);
      settle();
      next_cycle();
      drive(3'b000, 1'b0, 1'b1, 64'hC);
      exp_rsp(1, 64'hC);
      settle();
      next_cycle();

      // Error: response with nothing outstanding is sticky.
      drive(3'b000, 1'b0, 1'b1, 64'h55);
      settle();
      chk("err_rvalid_o", 128'(rvalid_o), 128'(0));
      next_cycle();
      drive(3'b000, 1'b0, 1'b0, '0);
      settle();
      chk("err_set", 128'(resp_err_o), 128'(1));
      next_cycle();
      settle();
      chk("err_sticky", 128'(resp_err_o), 128'(1));
      next_cycle();

      // Reset during HOLD with two outstanding.
      drive(3'b001, 1'b1, 1'b0, '0);
      exp_gnt(0);
      settle();
      next_cycle();
      drive(3'b010, 1'b1, 1'b0, '0);
      exp_gnt(1);
      settle();
      next_cycle();
      drive(3'b100, 1'b0, 1'b0, '0);
      settle();
      chk("pre_rst_hold_addr", 128'(addr_o), 128'(64'h80));
      next_cycle();
      rst = 1'b1;
      settle();
      next_cycle();
      rst = 1'b0;
      drive(3'b000, 1'b0, 1'b0, '0);
      settle();
      chk("rst2_req_o", 128'(req_o), 128'(0));
      chk("rst2_gnt_o", 128'(gnt_o), 128'(0));
      chk("rst2_rvalid_o", 128'(rvalid_o), 128'(0));
      chk("rst2_resp_err", 128'(resp_err_o), 128'(0));
      next_cycle();
      drive(3'b000, 1'b0, 1'b1, 64'h77);
      settle();
      chk("rst2_dropped_rsp", 128'(rvalid_o), 128'(0));
      next_cycle();
      drive(3'b000, 1'b0, 1'b0, '0);
      settle();
      chk("rst2_fifo_empty", 128'(resp_err_o), 128'(1));
      next_cycle();
      drive(3'b111, 1'b1, 1'b0, '0);
      exp_gnt(0);
      settle();
      next_cycle();
      drive(3'b000, 1'b0, 1'b1, 64'h99);
      exp_rsp(0, 64'h99);
      settle();
      next_cycle();
      drive(3'b000, 1'b0, 1'b0, '0);
      settle();

      chk("gnt_queue_drained", 128'(gq.size()), 128'(0));
      chk("rsp_queue_drained", 128'(rq.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
